// File: rtl/perm_arbiter.sv
// Grants one shared permutation core to one of two requesters for a whole message, round robin when both ask.
// Combinational block path; ack mirrors core_ack for the owner only; CLR->BUSY->WAIT->DONE is >=3 cycles plus the core's time.
module perm_arbiter #(
  parameter int BLOCK_W = 576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [BLOCK_W-1:0] in0,
  input  logic [BLOCK_W-1:0] in1,
  input  logic               in_ready0,
  input  logic               in_ready1,
  input  logic               last0,
  input  logic               last1,
  output logic               ack0,
  output logic               ack1,
  output logic               done0,
  output logic               done1,
  output logic [BLOCK_W-1:0] core_in,
  output logic               core_in_ready,
  input  logic               core_ack,
  input  logic               core_out_ready,
  output logic               core_reset,
  output logic               owner,
  output logic               busy,
  output logic [7:0]         blk_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    BUSY,
    WAIT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_served_q, last_served_d;
  logic [7:0] blk_cnt_q, blk_cnt_d;

  logic sel_in_ready;
  logic sel_last;

  assign sel_in_ready = owner_q ? in_ready1 : in_ready0;
  assign sel_last     = owner_q ? last1 : last0;

  // last_served resets to 1 so the first contended grant goes to requester 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      blk_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      blk_cnt_q     <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    blk_cnt_d     = blk_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = CLR;
          owner_d = (req0 && req1) ? ~last_served_q : req1;
        end
      end
      CLR: begin
        blk_cnt_d = 8'd0;
        state_d   = BUSY;
      end
      BUSY: begin
        if (core_ack) begin
          if (blk_cnt_q != 8'hFF) begin
            blk_cnt_d = blk_cnt_q + 8'd1;
          end
          if (sel_last) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (core_out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_served_d = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drives state to IDLE asynchronously, which silences every state-derived output
  assign core_in       = owner_q ? in1 : in0;
  assign core_in_ready = (state_q == BUSY) && sel_in_ready;
  assign ack0          = (state_q == BUSY) && !owner_q && core_ack;
  assign ack1          = (state_q == BUSY) && owner_q && core_ack;
  assign done0         = (state_q == DONE) && !owner_q;
  assign done1         = (state_q == DONE) && owner_q;
  assign core_reset    = !reset || (state_q == CLR);
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;
  assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_perm_arbiter.sv
// Directed message sequence with random block data, gaps and drops, checked against a transaction-level arbiter model.
module tb_perm_arbiter;
  localparam int BW = 576;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [BW-1:0] in0, in1;
  logic          in_ready0, in_ready1, last0, last1;
  logic          ack0, ack1, done0, done1;
  logic [BW-1:0] core_in;
  logic          core_in_ready, core_ack, core_out_ready, core_reset;
  logic          owner, busy;
  logic [7:0]    blk_cnt;

  int total  = 0;
  int passed = 0;
  bit ls;  // model: requester served most recently

  always #5 clk = ~clk;

  perm_arbiter #(.BLOCK_W(BW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .in_ready0(in_ready0), .in_ready1(in_ready1), .last0(last0), .last1(last1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .core_in(core_in), .core_in_ready(core_in_ready), .core_ack(core_ack),
    .core_out_ready(core_out_ready), .core_reset(core_reset),
    .owner(owner), .busy(busy), .blk_cnt(blk_cnt)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_quiet_reset();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_in_ready", core_in_ready, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_dones", {done1, done0}, 0);
  endtask

  // One whole message from IDLE back to IDLE; abort pulls reset while waiting for the core.
  task automatic run_msg(input bit r0, input bit r1, input int n, input bit drop, input bit abort);
    bit            own;
    int            gap;
    int            wt;
    int            exp_cnt;
    logic [BW-1:0] blk;
    own = (r0 && r1) ? ~ls : r1;
    req0 = r0;
    req1 = r1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_core_in_ready", core_in_ready, 0);
    step();
    chk("clr_core_reset", core_reset, 1);
    chk("clr_busy", busy, 1);
    chk("clr_owner", owner, own);
    chk("clr_core_in_ready", core_in_ready, 0);
    if (drop) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    step();
    chk("busy_core_reset", core_reset, 0);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      blk = rnd_blk();
      if (own) begin
        in1 = blk; in_ready1 = 1'b1; last1 = (i == n - 1);
        in0 = rnd_blk(); in_ready0 = 1'b1; last0 = 1'b1;
      end else begin
        in0 = blk; in_ready0 = 1'b1; last0 = (i == n - 1);
        in1 = rnd_blk(); in_ready1 = 1'b1; last1 = 1'b1;
      end
      core_ack = 1'b0;
      #1;
      chk("busy_blk_cnt", blk_cnt, (i > 255) ? 255 : i);
      chk("busy_core_in", core_in, blk);
      chk("busy_core_in_ready", core_in_ready, 1);
      for (int g = 0; g < gap; g++) begin
        chk("no_ack_without_core_ack", {ack1, ack0}, 0);
        step();
      end
      core_ack = 1'b1;
      #1;
      chk("ack_owner", own ? ack1 : ack0, 1);
      chk("ack_other", own ? ack0 : ack1, 0);
      step();
    end
    core_ack = 1'b0;
    in_ready0 = 1'b0; in_ready1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    #1;
    exp_cnt = (n > 255) ? 255 : n;
    chk("wait_blk_cnt", blk_cnt, exp_cnt);
    chk("wait_core_in_ready", core_in_ready, 0);
    chk("wait_busy", busy, 1);
    if (drop) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    if (abort) begin
      reset = 1'b0;
      #1;
      chk_quiet_reset();
      step();
      reset = 1'b1;
      ls = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      step();
      chk("abort_idle_busy", busy, 0);
      chk("abort_no_done", {done1, done0}, 0);
      return;
    end
    wt = $urandom_range(0, 3);
    for (int w = 0; w < wt; w++) begin
      chk("wait_no_done", {done1, done0}, 0);
      step();
      chk("wait_held", busy, 1);
    end
    core_out_ready = 1'b1;
    step();
    core_out_ready = 1'b0;
    #1;
    chk("done_owner", own ? done1 : done0, 1);
    chk("done_other", own ? done0 : done1, 0);
    chk("done_blk_cnt_hold", blk_cnt, exp_cnt);
    ls = own;
    step();
    chk("post_done_idle", busy, 0);
    chk("post_done_pulse_end", {done1, done0}, 0);
    chk("post_done_owner_hold", owner, own);
  endtask

  initial begin
    bit r0, r1, dr;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    in0 = '0; in1 = '0;
    in_ready0 = 1'b0; in_ready1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    core_ack = 1'b0; core_out_ready = 1'b0;
    ls = 1'b1;
    #2;
    chk_quiet_reset();
    req0 = 1'b1;
    step();
    chk("held_in_reset", busy, 0);
    req0 = 1'b0;
    reset = 1'b1;
    #1;
    chk("core_reset_released", core_reset, 0);
    step();
    chk("idle_no_req_stays", busy, 0);

    run_msg(1, 0, 3, 0, 0);
    run_msg(1, 1, 2, 0, 0);
    run_msg(1, 1, 1, 0, 0);
    run_msg(1, 1, 1, 0, 0);
    run_msg(0, 1, 4, 1, 0);
    run_msg(1, 0, 2, 1, 0);
    run_msg(1, 1, 2, 0, 1);
    run_msg(1, 1, 1, 0, 0);
    run_msg(1, 1, 301, 0, 0);
    for (int k = 0; k < 6; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      dr = 1'($urandom_range(0, 1));
      run_msg(r0, r1, $urandom_range(1, 5), dr, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/perm_arbiter.md
PERM_ARBITER -- requirements
Module: perm_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_W, default 576, width in bits of one absorbed rate block.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports req0/req1  input  1  requester x asks for the permutation core for one whole message.
REQ-005 SHALL have ports in0/in1  input  BLOCK_W  requester x rate block.
REQ-006 SHALL have ports in_ready0/in_ready1  input  1  requester x block valid.
REQ-007 SHALL have ports last0/last1  input  1  qualifies in_readyx; block is final block of message.
REQ-008 SHALL have ports ack0/ack1  output  1  requester x block consumed this cycle.
REQ-009 SHALL have ports done0/done1  output  1  one-cycle pulse; core state holds requester x digest.
REQ-010 SHALL have port core_in  output  BLOCK_W  block to core.
REQ-011 SHALL have port core_in_ready  output  1  block valid to core.
REQ-012 SHALL have port core_ack  input  1  core consumed core_in.
REQ-013 SHALL have port core_out_ready  input  1  core permutation complete.
REQ-014 SHALL have port core_reset  output  1  synchronous active-high clear to core.
REQ-015 SHALL have ports owner  output  1 (granted requester) and busy  output  1 (state != IDLE).
REQ-016 SHALL have port blk_cnt  output  8  blocks accepted in current message, saturating at 255.

Function
REQ-017 SHALL implement states IDLE, CLR, BUSY, WAIT, DONE.
REQ-018 IDLE: any reqx=1 -> CLR next cycle, owner latched; none -> stay.
REQ-019 Both reqs in IDLE: grant requester != last_served (round robin); single req: grant it.
REQ-020 CLR: exactly one cycle, core_reset=1, blk_cnt<=0, -> BUSY.
REQ-021 BUSY: core_in=in_owner, core_in_ready=in_ready_owner; non-owner inputs ignored.
REQ-022 ack_owner = core_ack (combinational); ack of non-owner always 0.
REQ-023 core_ack=1 in BUSY: blk_cnt increments (saturating); if last_owner=1 -> WAIT, else stay BUSY.
REQ-024 core_in_ready SHALL be 0 in IDLE, CLR, WAIT, DONE; core_in held at in_owner (don't-care when not ready).
REQ-025 WAIT: core_out_ready=1 -> DONE; otherwise stay (no timeout).
REQ-026 DONE: done_owner=1 for one cycle, last_served<=owner, -> IDLE; blk_cnt and owner hold until next CLR.
REQ-027 Grant is locked from CLR to DONE; reqx deassertion during that span SHALL be ignored.
REQ-028 Reqs seen in DONE cycle SHALL not be granted until IDLE (min 1 idle cycle between messages).
REQ-029 Requester with in_ready and last on first block SHALL yield blk_cnt=1 and one permutation.
REQ-030 core_reset = (reset==0) | (state==CLR), combinational.

Reset
REQ-031 reset=0 SHALL immediately force state=IDLE, owner=0, last_served=1, blk_cnt=0, done0=done1=0, ack0=ack1=0, core_in_ready=0, busy=0, core_reset=1.
REQ-032 Reset asserted mid-message SHALL abandon it with no done pulse; after release, arbitration restarts from IDLE with req0 priority.

Verification
REQ-033 req0=1, 3 blocks (last on 3rd), core acks each -> CLR pulse, ack0 x3, blk_cnt=3, done0 one cycle after core_out_ready, done1 never.
REQ-034 req0=req1=1 from reset -> owner=0 first; after done0, owner=1 served next, then owner=0 on repeat.
REQ-035 Owner 0 BUSY while in_ready1=1, last1=1 -> ack1=0, core_in equals in0, blk_cnt counts only owner blocks.
REQ-036 req0 dropped during WAIT -> grant held, done0 still pulses on core_out_ready.
REQ-037 reset=0 for one cycle in WAIT -> busy=0, no done0, core_reset=1 asynchronously; next req0 sees new CLR.
REQ-038 300 non-last blocks then last -> blk_cnt saturates at 255, done issued normally.
